// File: rtl/a5_stream_controller_pkg.sv
// Shared constants and state encodings for the A5/1 stream controller.
package a5_pkg;

    localparam int unsigned KEY_W       = 64;
    localparam int unsigned FRAME_W     = 22;
    localparam int unsigned MIX_DEFAULT = 100;
    localparam int unsigned IMG_BITS    = 524288;

    localparam int unsigned ST_W    = 3;
    localparam int unsigned SETUP_W = 7;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLR    = 3'd1;
    localparam logic [2:0] ST_KEY    = 3'd2;
    localparam logic [2:0] ST_FRAME  = 3'd3;
    localparam logic [2:0] ST_MIX    = 3'd4;
    localparam logic [2:0] ST_STREAM = 3'd5;
    localparam logic [2:0] ST_DRAIN  = 3'd6;
    localparam logic [2:0] ST_DONE   = 3'd7;

endpackage

// File: rtl/a5_stream_controller_if.sv
// Bit-serial input and output handshakes of the stream controller.
interface a5_stream_controller_if;

    logic in_valid;
    logic in_ready;
    logic in_bit;
    logic out_valid;
    logic out_ready;
    logic out_bit;

    modport master (
        output in_valid, in_bit, out_ready,
        input  in_ready, out_valid, out_bit
    );

    modport slave (
        input  in_valid, in_bit, out_ready,
        output in_ready, out_valid, out_bit
    );

endinterface

// File: rtl/a5_skid_out.sv
// Single-entry output register with valid/ready and a synchronous flush.
module a5_skid_out (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic push,
    input  logic push_bit,
    input  logic pop_ready,
    output logic valid,
    output logic data
);

    // Load on push, empty on pop without push, flush wins over both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (push) begin
            valid <= 1'b1;
            data  <= push_bit;
        end else if (pop_ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/a5_stream_controller.sv
// Frame sequencer for one A5/1 generator plus a handshaked XOR stage.
module a5_stream_controller
    import a5_pkg::*;
#(
    parameter int unsigned TOTAL_BITS = IMG_BITS,
    parameter int unsigned CNT_W      = 20,
    parameter int unsigned MIX_CYCLES = MIX_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [KEY_W-1:0]       key,
    input  logic [FRAME_W-1:0]     frame,
    output logic                   gen_clr,
    output logic                   gen_load,
    output logic                   gen_load_bit,
    output logic                   gen_step,
    input  logic                   gen_ks,
    a5_stream_controller_if.slave  sif,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       bit_count
);

    logic [ST_W-1:0]    state, state_nxt;
    logic [SETUP_W-1:0] setup_cnt, setup_cnt_nxt;
    logic [KEY_W-1:0]   key_q;
    logic [FRAME_W-1:0] frame_q;
    logic               capture;
    logic               accept;
    logic               flush;

    // State and setup counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            setup_cnt <= '0;
        end else begin
            state     <= state_nxt;
            setup_cnt <= setup_cnt_nxt;
        end
    end

    // Next state, generator controls and stream handshake.
    always_comb begin
        state_nxt     = state;
        setup_cnt_nxt = setup_cnt;
        capture       = 1'b0;
        accept        = 1'b0;
        gen_clr       = 1'b0;
        gen_load      = 1'b0;
        gen_load_bit  = 1'b0;
        gen_step      = 1'b0;
        sif.in_ready  = 1'b0;
        busy          = (state != ST_IDLE);
        done          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    capture       = 1'b1;
                    state_nxt     = ST_CLR;
                    setup_cnt_nxt = '0;
                end
            end
            ST_CLR: begin
                gen_clr       = 1'b1;
                state_nxt     = ST_KEY;
                setup_cnt_nxt = '0;
            end
            ST_KEY: begin
                gen_load     = 1'b1;
                gen_load_bit = key_q[setup_cnt[5:0]];
                if (setup_cnt == SETUP_W'(KEY_W - 1)) begin
                    state_nxt     = ST_FRAME;
                    setup_cnt_nxt = '0;
                end else begin
                    setup_cnt_nxt = setup_cnt + SETUP_W'(1);
                end
            end
            ST_FRAME: begin
                gen_load     = 1'b1;
                gen_load_bit = frame_q[setup_cnt[4:0]];
                if (setup_cnt == SETUP_W'(FRAME_W - 1)) begin
                    state_nxt     = ST_MIX;
                    setup_cnt_nxt = '0;
                end else begin
                    setup_cnt_nxt = setup_cnt + SETUP_W'(1);
                end
            end
            ST_MIX: begin
                gen_step = 1'b1;
                if (setup_cnt == SETUP_W'(MIX_CYCLES - 1)) begin
                    state_nxt     = ST_STREAM;
                    setup_cnt_nxt = '0;
                end else begin
                    setup_cnt_nxt = setup_cnt + SETUP_W'(1);
                end
            end
            ST_STREAM: begin
                sif.in_ready = !sif.out_valid || sif.out_ready;
                accept       = sif.in_valid && sif.in_ready && !abort;
                gen_step     = accept;
                if (accept && (bit_count == CNT_W'(TOTAL_BITS - 1))) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!sif.out_valid || sif.out_ready) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        // Cancel overrides every other transition.
        if (abort && (state != ST_IDLE)) begin
            state_nxt     = ST_IDLE;
            setup_cnt_nxt = '0;
        end
    end

    assign flush = abort && (state != ST_IDLE);

    // Key/frame shadow capture and accepted-bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q     <= '0;
            frame_q   <= '0;
            bit_count <= '0;
        end else if (capture) begin
            key_q     <= key;
            frame_q   <= frame;
            bit_count <= '0;
        end else if (accept) begin
            bit_count <= bit_count + CNT_W'(1);
        end
    end

    a5_skid_out u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (accept),
        .push_bit  (sif.in_bit ^ gen_ks),
        .pop_ready (sif.out_ready),
        .valid     (sif.out_valid),
        .data      (sif.out_bit)
    );

endmodule
